ifmap_prefetch_fifo: RTL and testbench

IFMAP_PREFETCH_FIFO -- requirements
Module: ifmap_prefetch_fifo

---
 rtl/ifmap_prefetch_fifo_pkg.sv | 15 +
 rtl/ifmap_prefetch_fifo_mem.sv | 24 ++
 rtl/ifmap_prefetch_fifo.sv | 123 ++++++++++++
 tb/tb_ifmap_prefetch_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_prefetch_fifo_pkg.sv
// Ifmap prefetch FIFO: shared accelerator defaults.
// Word width, FIFO depth (log2) and stop-request margin.
package ifmap_prefetch_fifo_pkg;

  localparam int IFM_DATA_WIDTH = 8;
  localparam int IFM_DEPTH_LOG2 = 4;
  localparam int IFM_AF_MARGIN  = 4;

  // Occupancy level at which off-chip reads are paused.
  function automatic int stop_level(input int depth_log2,
                                    input int margin);
    return (1 << depth_log2) - margin;
  endfunction

endpackage

// File: rtl/ifmap_prefetch_fifo_mem.sv
// Ifmap prefetch FIFO storage: 1 write port, 1 async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module ifmap_prefetch_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifmap_prefetch_fifo.sv
// Ifmap prefetch FIFO: captures off-chip reads (1-cycle latency),
// feeds the datapath, and requests a read pause when nearly full.
// Ports: Clk, Reset (sync, active-low), Flush, Offmem_Re/Rdata in,
// Dp_Ready in, Dp_Data/Dp_Valid/Stop_Feeding/Count/Overflow out.
// Macro IFMAP_PREFETCH_FIFO_OVF_FLAG_EN enables the sticky Overflow.
module ifmap_prefetch_fifo
  import ifmap_prefetch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = IFM_DEPTH_LOG2,
  parameter int AF_MARGIN  = IFM_AF_MARGIN
) (
  input  logic                  IFMAP_PREFETCH_FIFO_Clk,
  input  logic                  IFMAP_PREFETCH_FIFO_Reset,
  input  logic                  IFMAP_PREFETCH_FIFO_Flush,
  input  logic                  IFMAP_PREFETCH_FIFO_Offmem_Re,
  input  logic [DATA_WIDTH-1:0] IFMAP_PREFETCH_FIFO_Offmem_Rdata,
  input  logic                  IFMAP_PREFETCH_FIFO_Dp_Ready,
  output logic [DATA_WIDTH-1:0] IFMAP_PREFETCH_FIFO_Dp_Data,
  output logic                  IFMAP_PREFETCH_FIFO_Dp_Valid,
  output logic                  IFMAP_PREFETCH_FIFO_Stop_Feeding,
  output logic [DEPTH_LOG2:0]   IFMAP_PREFETCH_FIFO_Count,
  output logic                  IFMAP_PREFETCH_FIFO_Overflow
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW:0] STOP_LVL =
    (CW+1)'(stop_level(DEPTH_LOG2, AF_MARGIN));

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [CW:0]           level_d;
  logic                  inflight_q;
  logic                  stop_q;
  logic                  full;
  logic                  pop;
  logic                  push_ok;

  assign clk   = IFMAP_PREFETCH_FIFO_Clk;
  assign rst_n = IFMAP_PREFETCH_FIFO_Reset;
  assign flush = IFMAP_PREFETCH_FIFO_Flush;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = IFMAP_PREFETCH_FIFO_Dp_Valid
              & IFMAP_PREFETCH_FIFO_Dp_Ready;
  // A full FIFO still accepts a word when a pop frees a slot.
  assign push_ok = inflight_q & (~full | pop);

  always_comb begin
    count_d = count_q;
    if (push_ok & ~pop)
      count_d = count_q + CW'(1);
    else if (~push_ok & pop)
      count_d = count_q - CW'(1);
  end

  // Count the read being issued now: it lands next cycle.
  assign level_d = {1'b0, count_d}
                 + (CW+1)'(IFMAP_PREFETCH_FIFO_Offmem_Re);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      stop_q     <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      inflight_q <= IFMAP_PREFETCH_FIFO_Offmem_Re;
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_d;
      stop_q  <= (level_d >= STOP_LVL);
    end
  end

  ifmap_prefetch_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok & rst_n & ~flush),
    .waddr (wr_ptr_q),
    .wdata (IFMAP_PREFETCH_FIFO_Offmem_Rdata),
    .raddr (rd_ptr_q),
    .rdata (IFMAP_PREFETCH_FIFO_Dp_Data)
  );

  assign IFMAP_PREFETCH_FIFO_Dp_Valid     = (count_q != '0);
  assign IFMAP_PREFETCH_FIFO_Stop_Feeding = stop_q;
  assign IFMAP_PREFETCH_FIFO_Count        = count_q;

`ifdef IFMAP_PREFETCH_FIFO_OVF_FLAG_EN
  logic ovf_q;

  // Sticky until reset; a flush discards the returning word instead.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (inflight_q & full & ~pop & ~flush)
      ovf_q <= 1'b1;
  end

  assign IFMAP_PREFETCH_FIFO_Overflow = ovf_q;
`else
  assign IFMAP_PREFETCH_FIFO_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ifmap_prefetch_fifo.sv
// Directed bench for ifmap_prefetch_fifo (default parameters).
// Vector table plus hand sequences for multi-cycle corners.
module tb_ifmap_prefetch_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       re;
  logic [7:0] rdata;
  logic       rdy;
  logic [7:0] dp_data;
  logic       dp_valid;
  logic       stop;
  logic [4:0] count;
  logic       ovf;

  int errors = 0;
  int checks = 0;

`ifdef IFMAP_PREFETCH_FIFO_OVF_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef struct {
    logic       re;
    logic [7:0] rd;
    logic       rdy;
    logic       fl;
    logic       ev;
    logic [4:0] ec;
    logic [7:0] ed;
    logic       es;
  } vec_t;

  vec_t tv [13];

  always #5 clk = ~clk;

  ifmap_prefetch_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_LOG2 (4),
    .AF_MARGIN  (4)
  ) dut (
    .IFMAP_PREFETCH_FIFO_Clk          (clk),
    .IFMAP_PREFETCH_FIFO_Reset        (rst_n),
    .IFMAP_PREFETCH_FIFO_Flush        (flush),
    .IFMAP_PREFETCH_FIFO_Offmem_Re    (re),
    .IFMAP_PREFETCH_FIFO_Offmem_Rdata (rdata),
    .IFMAP_PREFETCH_FIFO_Dp_Ready     (rdy),
    .IFMAP_PREFETCH_FIFO_Dp_Data      (dp_data),
    .IFMAP_PREFETCH_FIFO_Dp_Valid     (dp_valid),
    .IFMAP_PREFETCH_FIFO_Stop_Feeding (stop),
    .IFMAP_PREFETCH_FIFO_Count        (count),
    .IFMAP_PREFETCH_FIFO_Overflow     (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int first_stop;
    int e;
    int exp_w;

    tv[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    tv[1]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 1'b0};
    tv[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 1'b0};
    tv[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 5'd2, 8'hA5, 1'b0};
    tv[4]  = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 5'd2, 8'h3C, 1'b0};
    tv[5]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 5'd1, 8'h5A, 1'b0};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    tv[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};
    tv[9]  = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 5'd1, 8'h11, 1'b0};
    tv[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 8'h11, 1'b0};
    tv[11] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0};
    tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0};

    // Reset held 3 cycles with reads requested
    rst_n = 1'b0;
    flush = 1'b0;
    re    = 1'b1;
    rdata = 8'h77;
    rdy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_count", count, 0);
      chk("rst_valid", dp_valid, 0);
      chk("rst_stop", stop, 0);
      chk("rst_ovf", ovf, 0);
    end
    re    = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", count, 0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      re    = tv[i].re;
      rdata = tv[i].rd;
      rdy   = tv[i].rdy;
      flush = tv[i].fl;
      tick();
      chk($sformatf("v%0d_valid", i), dp_valid, tv[i].ev);
      chk($sformatf("v%0d_count", i), count, tv[i].ec);
      chk($sformatf("v%0d_stop", i), stop, tv[i].es);
      if (tv[i].ev)
        chk($sformatf("v%0d_data", i), dp_data, tv[i].ed);
    end
    flush = 1'b0;

    // Stop threshold: upstream honours stop immediately
    rdy = 1'b0;
    first_stop = 0;
    for (e = 1; e <= 20; e++) begin
      re    = ~stop;
      rdata = 8'(8'h80 + e);
      tick();
      if (stop && first_stop == 0) begin
        first_stop = e;
        chk("stop_rise_count", count, 11);
      end
    end
    chk("stop_rise_edge", first_stop, 12);
    chk("stop_final_count", count, 12);
    chk("stop_count_le16", count <= 16, 1);
    chk("stop_held", stop, 1);
    chk("stop_ovf", ovf, 0);
    chk("stop_head", dp_data, 8'h82);

    // Ignore stop: fill to 16, then one more word arrives
    for (e = 21; e <= 26; e++) begin
      re    = (e <= 25);
      rdata = 8'(8'h80 + e);
      tick();
    end
    chk("ovf_count", count, 16);
    chk("ovf_flag", ovf, OVF_EXP);
    chk("ovf_head", dp_data, 8'h82);

    // Push and pop together while full
    re    = 1'b1;
    tick();
    re    = 1'b0;
    rdy   = 1'b1;
    rdata = 8'h9C;
    tick();
    chk("full_pp_count", count, 16);
    chk("full_pp_head", dp_data, 8'h83);

    rdy   = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", dp_valid, 0);
    chk("flush_stop", stop, 0);
    chk("flush_keeps_ovf", ovf, OVF_EXP);

    // Stream 40 words with the datapath always ready
    rdy   = 1'b1;
    exp_w = 0;
    for (int i = 0; i < 44; i++) begin
      re    = (i < 40);
      rdata = 8'(i - 1);
      if (dp_valid) begin
        chk("stream_data", dp_data, exp_w);
        exp_w++;
      end
      tick();
      chk("stream_count_le1", count <= 1, 1);
    end
    chk("stream_total", exp_w, 40);

    // Flush with Count=7 and a read in flight
    rdy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      re    = 1'b1;
      rdata = 8'(8'h40 + i);
      tick();
    end
    chk("pre_flush_count", count, 7);
    re    = 1'b0;
    flush = 1'b1;
    rdata = 8'hEE;
    tick();
    flush = 1'b0;
    chk("flush7_count", count, 0);
    chk("flush7_valid", dp_valid, 0);
    tick();
    chk("flush7_no_late", count, 0);

    // Reset mid-stream
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdata = 8'(8'h60 + i);
      tick();
    end
    chk("mid_pre_count", count, 2);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", dp_valid, 0);
    chk("mid_rst_ovf", ovf, 0);
    rst_n = 1'b1;
    re    = 1'b0;
    rdata = 8'hEE;
    tick();
    chk("mid_rel_count", count, 0);
    re = 1'b1;
    tick();
    re    = 1'b0;
    rdata = 8'h5C;
    tick();
    chk("mid_first_count", count, 1);
    chk("mid_first_data", dp_data, 8'h5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
